instr_loader: RTL and testbench
===============================

# instr_loader

Write-side companion to the instruction memory. Accepts a byte stream (MSB first) from a host/testbench port, packs four bytes into a 32-bit instruction and issues one-cycle write strobes at byte addresses 0, 4, 8, … so that a word-indexed memory (index = addr/4) is filled in order. It sits between the program source and the memory's write port, and tells the CPU side when the image is complete.

## Interface
- DEPTH, 32, number of 32-bit words in the target memory; load length is clamped to this.
- CNT_W, 16, width of num_words_i and word_count_o.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  begin a load; sampled only in IDLE.
- num_words_i  input  CNT_W  words to load; latched on accepted start.
- abort_i  input  1  cancel the current load.
- byte_i  input  8  stream byte.
- byte_valid_i  input  1  byte_i is valid.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- wr_en_o  output  1  one-cycle write strobe.
- wr_addr_o  output  32  byte address of the write (word index × 4).
- wr_data_o  output  32  packed instruction.
- busy_o  output  1  load in progress (COLLECT or WRITE).
- done_o  output  1  one-cycle pulse: load completed normally.
- word_count_o  output  CNT_W  words written in the current/last load.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: start_i=1 → latch len = min(num_words_i, DEPTH); clear word index, byte counter, word_count_o. If len=0 → DONE, else → COLLECT.
- COLLECT: byte_ready_o=1. Byte accepted when byte_valid_i & byte_ready_o at clock edge; shift register ← {shift[23:0], byte_i}, byte counter +1 (mod 4). On the 4th accepted byte → WRITE.
- WRITE: byte_ready_o=0; wr_en_o=1, wr_data_o = packed word (first byte in [31:24]), wr_addr_o = word_index<<2. Next edge: word_index+1, word_count_o+1; if word_count reaches len → DONE, else → COLLECT.
- DONE: done_o=1 for exactly one cycle, → IDLE. word_count_o holds until next accepted start.
- abort_i in COLLECT or WRITE: → IDLE next edge; partial word discarded; a WRITE-state strobe in the abort cycle is suppressed (wr_en_o gated by ~abort_i); done_o not asserted. abort_i in IDLE/DONE ignored.
- start_i outside IDLE ignored. byte_valid_i outside COLLECT ignored (no byte consumed).
- wr_addr_o/wr_data_o hold their last values when wr_en_o=0.
- Addresses never exceed (DEPTH-1)×4; no wrap-around occurs because len is clamped.

## Timing
- Reset (rst_i=0, asynchronous): state=IDLE; byte_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, word_count_o=0; shift register and counters cleared. Reset mid-load discards everything; no strobe issued.
- All outputs registered or decoded from state only; no combinational path from byte_valid_i to byte_ready_o.
- Latency: 4th byte accepted at edge N → wr_en_o high in cycle N+1 → COLLECT (ready) again from edge N+2. Max throughput: one word per 5 cycles.
- Last word: strobe in cycle N+1, done_o in cycle N+2, busy_o falls at edge N+2.
- len=0: start at edge S → done_o in cycle S+1, no strobe.
- Target memory write must be synchronous on clk_i with write-enable; data/address valid for the whole strobe cycle.

## Test plan
- Reset mid-COLLECT after 2 bytes → all outputs 0 immediately, no wr_en_o; after release, new start with 1 word, bytes 0x01,0x02,0x03,0x04 → single write addr 0x0, data 0x01020304.
- start num_words_i=3, 12 bytes 0x00..0x0B back-to-back → writes (0x0,0x00010203),(0x4,0x04050607),(0x8,0x08090A0B); byte_ready_o low in each WRITE cycle; done_o one cycle after 3rd strobe; word_count_o=3.
- Same load with byte_valid_i toggling every other cycle → identical writes/data; no byte lost or duplicated.
- num_words_i=40 with DEPTH=32 → exactly 32 strobes, last addr 0x7C, done_o, word_count_o=32.
- num_words_i=0 → done_o one cycle after start, no strobe; start_i pulsed while busy in another load → ignored, len unchanged.
- abort_i after 6 bytes of a 2-word load → one write (addr 0x0), then IDLE, no done_o, word_count_o=1; abort_i coinciding with WRITE of word 2 → no strobe for it.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: packs an MSB-first byte stream into 32-bit words and issues
// sequential write strobes (byte address 0, 4, 8, ...) to a word-indexed memory.
module instr_loader #(
   parameter int DEPTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] num_words_i,
   input  logic             abort_i,
   input  logic [7:0]       byte_i,
   input  logic             byte_valid_i,
   output logic             byte_ready_o,
   output logic             wr_en_o,
   output logic [31:0]      wr_addr_o,
   output logic [31:0]      wr_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] word_count_o
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   // Only the first three bytes are buffered; the fourth goes straight into the word.
   logic [23:0]      shift_q, shift_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         count_q    <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         count_q    <= count_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      count_d    = count_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      addr_d     = addr_q;
      data_d     = data_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               len_d      = (num_words_i > DEPTH_C) ? DEPTH_C : num_words_i;
               count_d    = '0;
               byte_cnt_d = '0;
               shift_d    = '0;
               state_d    = (num_words_i == '0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (abort_i) begin
               byte_cnt_d = '0;
               shift_d    = '0;
               state_d    = S_IDLE;
            end else if (byte_valid_i) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               shift_d    = {shift_q[15:0], byte_i};
               // Address and data are captured here so they stay stable through the strobe.
               if (byte_cnt_q == 2'd3) begin
                  data_d  = {shift_q, byte_i};
                  addr_d  = 32'({count_q, 2'b00});
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else begin
               count_d = count_q + 1'b1;
               state_d = (count_d == len_q) ? S_DONE : S_COLLECT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign byte_ready_o = (state_q == S_COLLECT);
   assign wr_en_o      = (state_q == S_WRITE) && !abort_i;
   assign busy_o       = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign done_o       = (state_q == S_DONE);
   assign wr_addr_o    = addr_q;
   assign wr_data_o    = data_q;
   assign word_count_o = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized bench for instr_loader, compared against a
// word-list model of the memory image each load should produce.
`timescale 1ns/1ps
module tb_instr_loader;
   localparam int DEPTH = 32;
   localparam int CNT_W = 16;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [CNT_W-1:0] num_words_i;
   logic             abort_i;
   logic [7:0]       byte_i;
   logic             byte_valid_i;
   logic             byte_ready_o;
   logic             wr_en_o;
   logic [31:0]      wr_addr_o;
   logic [31:0]      wr_data_o;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] word_count_o;

   instr_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_words_i(num_words_i),
      .abort_i(abort_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
      .byte_ready_o(byte_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .word_count_o(word_count_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int k = 0;
   int start_cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int acc_cnt = 0;
   int rdy_in_wr = 0;
   logic [7:0]  stim [0:255];
   logic [31:0] obs_addr [$];
   logic [31:0] obs_data [$];
   int          obs_cyc [$];
   int          fourth_cyc [$];

   always @(posedge clk_i) cyc <= cyc + 1;

   // Observer: samples on the falling edge, away from the active edge.
   always @(negedge clk_i) begin
      if (wr_en_o) begin
         obs_addr.push_back(wr_addr_o);
         obs_data.push_back(wr_data_o);
         obs_cyc.push_back(cyc);
         if (byte_ready_o) rdy_in_wr++;
      end
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (byte_valid_i && byte_ready_o && !abort_i) begin
         acc_cnt++;
         if (acc_cnt % 4 == 0) fourth_cyc.push_back(cyc);
      end
   end

   // Reference model: word i of the image is bytes 4i..4i+3, first byte most significant.
   function automatic logic [31:0] exp_word(input int i);
      return {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
   endfunction

   task automatic clear_mon();
      obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); fourth_cyc.delete();
      done_cnt = 0; done_cyc = -1; acc_cnt = 0; rdy_in_wr = 0; k = 0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
   endtask

   task automatic do_start(input int n);
      start_i = 1'b1;
      num_words_i = CNT_W'(n);
      start_cyc = cyc;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      num_words_i = CNT_W'($urandom);
   endtask

   // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
   task automatic feed(input int upto, input int mode, input int restart_at);
      int b = 0;
      bit pulsed = 1'b0;
      bit v;
      while (k < upto && b < 2000) begin
         if (mode == 0) v = 1'b1;
         else if (mode == 1) v = (b % 2 == 0);
         else v = ($urandom_range(0, 1) == 1);
         byte_valid_i = v;
         byte_i = v ? stim[k] : 8'($urandom);
         if (k == restart_at && !pulsed) begin
            start_i = 1'b1;
            num_words_i = CNT_W'(5);
            pulsed = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk_i);
         if (v && byte_ready_o) k++;
         @(posedge clk_i); #1;
         b++;
      end
      byte_valid_i = 1'b0;
      start_i = 1'b0;
      checks++;
      if (k < upto) begin
         errors++;
         $display("FAIL feed_timeout: accepted %0d bytes, required %0d", k, upto);
      end
   endtask

   task automatic wait_done();
      int b = 0;
      while (done_cnt == 0 && b < 50) begin
         @(posedge clk_i); #1;
         b++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL done_timeout: done_o count %0d after %0d cycles, required 1", done_cnt, b);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({byte_ready_o, wr_en_o, busy_o, done_o} !== 4'b0000 || wr_addr_o !== 32'h0 ||
          wr_data_o !== 32'h0 || word_count_o !== '0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b wr_en=%b busy=%b done=%b addr=%h data=%h cnt=%0d, required all 0",
                  byte_ready_o, wr_en_o, busy_o, done_o, wr_addr_o, wr_data_o, word_count_o);
      end
   endtask

   task automatic test_reset_mid_load();
      clear_mon();
      for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
      do_start(1);
      feed(2, 0, -1);
      #2 rst_i = 1'b0;
      #1;
      checks++;
      if ({byte_ready_o, wr_en_o, busy_o, done_o} !== 4'b0000 || wr_addr_o !== 32'h0 ||
          wr_data_o !== 32'h0 || word_count_o !== '0) begin
         errors++;
         $display("FAIL reset_async: rdy=%b wr_en=%b busy=%b done=%b addr=%h data=%h cnt=%0d, required all 0",
                  byte_ready_o, wr_en_o, busy_o, done_o, wr_addr_o, wr_data_o, word_count_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      checks++;
      if (obs_addr.size() != 0) begin
         errors++;
         $display("FAIL reset_no_strobe: %0d strobes, required 0", obs_addr.size());
      end
      clear_mon();
      do_start(1);
      feed(4, 0, -1);
      wait_done();
      checks++;
      if (obs_addr.size() != 1 || obs_addr[0] !== 32'h0 || obs_data[0] !== 32'h01020304) begin
         errors++;
         $display("FAIL after_reset_write: %0d strobes first addr=%h data=%h, required 1 strobe addr=0 data=01020304",
                  obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 32'hx,
                  (obs_data.size() > 0) ? obs_data[0] : 32'hx);
      end
   endtask

   task automatic test_load(input int n, input int mode, input int restart_at);
      int len;
      int exp_done;
      len = (n > DEPTH) ? DEPTH : n;
      clear_mon();
      do_start(n);
      feed(4 * len, mode, restart_at);
      wait_done();
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if (obs_addr.size() != len) begin
         errors++;
         $display("FAIL write_count n=%0d: got %0d strobes, required %0d", n, obs_addr.size(), len);
      end
      for (int i = 0; i < len && i < obs_addr.size(); i++) begin
         checks++;
         if (obs_addr[i] !== 32'(i * 4) || obs_data[i] !== exp_word(i)) begin
            errors++;
            $display("FAIL word%0d n=%0d: addr=%h data=%h, required addr=%h data=%h",
                     i, n, obs_addr[i], obs_data[i], 32'(i * 4), exp_word(i));
         end
      end
      for (int i = 0; i < obs_cyc.size() && i < fourth_cyc.size(); i++) begin
         checks++;
         if (obs_cyc[i] != fourth_cyc[i] + 1) begin
            errors++;
            $display("FAIL strobe_latency word%0d: strobe cycle %0d, required %0d", i, obs_cyc[i], fourth_cyc[i] + 1);
         end
      end
      checks++;
      if (rdy_in_wr != 0) begin
         errors++;
         $display("FAIL ready_in_write: byte_ready_o high in %0d strobe cycles, required 0", rdy_in_wr);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL done_pulses n=%0d: got %0d, required 1", n, done_cnt);
      end
      if (len == 0) exp_done = start_cyc + 1;
      else exp_done = (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size() - 1] + 1 : -2;
      checks++;
      if (done_cyc != exp_done) begin
         errors++;
         $display("FAIL done_timing n=%0d: done cycle %0d, required %0d", n, done_cyc, exp_done);
      end
      checks++;
      if (word_count_o !== CNT_W'(len) || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL end_state n=%0d: word_count=%0d busy=%b, required %0d and 0", n, word_count_o, busy_o, len);
      end
   endtask

   task automatic test_abort_collect();
      clear_mon();
      fill_random();
      do_start(2);
      feed(6, 0, -1);
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (obs_addr.size() != 1 || obs_addr[0] !== 32'h0 || obs_data[0] !== exp_word(0)) begin
         errors++;
         $display("FAIL abort_collect_writes: %0d strobes, required 1 at addr 0 data %h", obs_addr.size(), exp_word(0));
      end
      checks++;
      if (done_cnt != 0 || word_count_o !== CNT_W'(1) || busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_collect_state: done=%0d cnt=%0d busy=%b rdy=%b, required 0 1 0 0",
                  done_cnt, word_count_o, busy_o, byte_ready_o);
      end
   endtask

   task automatic test_abort_write();
      clear_mon();
      fill_random();
      do_start(2);
      feed(8, 0, -1);
      abort_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (wr_en_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_write_strobe: wr_en_o=%b during aborted write, required 0", wr_en_o);
      end
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if (obs_addr.size() != 1 || done_cnt != 0 || word_count_o !== CNT_W'(1) || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_write_state: strobes=%0d done=%0d cnt=%0d busy=%b, required 1 0 1 0",
                  obs_addr.size(), done_cnt, word_count_o, busy_o);
      end
   endtask

   initial begin
      rst_i = 1'b0;
      start_i = 1'b0;
      num_words_i = '0;
      abort_i = 1'b0;
      byte_i = '0;
      byte_valid_i = 1'b0;
      #12;
      test_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      test_reset_mid_load();

      for (int i = 0; i < 12; i++) stim[i] = 8'(i);
      test_load(3, 0, -1);
      test_load(3, 1, -1);

      fill_random();
      test_load(40, 0, -1);
      test_load(0, 0, -1);

      fill_random();
      test_load(2, 0, 2);

      test_abort_collect();
      fill_random();
      test_load(1, 2, -1);
      test_abort_write();

      for (int r = 0; r < 4; r++) begin
         fill_random();
         test_load($urandom_range(1, 9), $urandom_range(0, 2), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
